// File: rtl/rr_arb_mux.sv
// N:1 registered selector with round-robin arbitration and a fixed-select override.
// One-entry output register; valid/ready handshakes on every port.
module rr_arb_mux #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 force_en,
    input  logic [SELW-1:0]      force_sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SELW-1:0]  ptr_q,       ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_src_q,   out_src_d;

    logic             can_load;
    logic             rr_found;
    logic [SELW-1:0]  rr_idx;
    logic             force_ok;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic             accept;

    // Modular add for channel indices; both operands are always below N.
    function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return s[SELW-1:0];
    endfunction

    assign can_load = !out_valid_q || out_ready;

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < N; k++) begin
            logic [SELW-1:0] cand;
            cand = wrap_add(ptr_q, k);
            if (!rr_found && in_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // An out-of-range force_sel must never reach the in_valid index.
    assign force_ok = (int'(force_sel) < N) && in_valid[force_sel];

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (force_en) begin
            grant_vld = force_ok;
            grant_idx = force_sel;
        end else begin
            grant_vld = rr_found;
            grant_idx = rr_idx;
        end
    end

    assign accept = grant_vld && can_load;

    // in_ready is gated by rst_n so nothing looks accepted while reset is held.
    always_comb begin
        in_ready = '0;
        if (rst_n && accept) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_src_d   = grant_idx;
            if (!force_en) begin
                ptr_d = wrap_add(grant_idx, 1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: directed stimulus pushes expected words,
// a negedge monitor pops and compares on every output transfer.
module tb_rr_arb_mux;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic         force_en;
    logic [1:0]   force_sel;
    logic [31:0]  out_data;
    logic [1:0]   out_src;
    logic         out_valid;
    logic         out_ready;

    logic [39:0]  in_data2;
    logic [4:0]   in_valid2;
    logic [4:0]   in_ready2;
    logic         force_en2;
    logic [2:0]   force_sel2;
    logic [7:0]   out_data2;
    logic [2:0]   out_src2;
    logic         out_valid2;
    logic         out_ready2;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  src;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    rr_arb_mux #(.WIDTH(32), .N(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .force_en(force_en), .force_sel(force_sel),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(8), .N(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .force_en(force_en2), .force_sel(force_sel2),
        .out_data(out_data2), .out_src(out_src2), .out_valid(out_valid2),
        .out_ready(out_ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] s);
        exp_t e;
        e.data = d;
        e.src  = s;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_unexpected: got data %0h src %0d expected no transfer", out_data, out_src);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_data", out_data, mon_e.data);
                chk("mon_src", {30'd0, out_src}, {30'd0, mon_e.src});
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        in_data    = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        in_valid   = 4'hF;
        out_ready  = 1'b1;
        force_en   = 1'b0;
        force_sel  = 2'd0;
        in_data2   = {8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0};
        in_valid2  = 5'd0;
        out_ready2 = 1'b1;
        force_en2  = 1'b0;
        force_sel2 = 3'd0;

        // reset: in_ready held low even with requests pending
        #3;
        chk("rst_in_ready", {28'd0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
        repeat (2) tick();
        in_valid = 4'h0;
        rst_n    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("idle_out_valid", {31'd0, out_valid}, 32'h0);
            chk("idle_in_ready", {28'd0, in_ready}, 32'h0);
            chk("idle_out_data", out_data, 32'h0);
            chk("idle_out_src", {30'd0, out_src}, 32'h0);
            tick();
        end

        // full round-robin rotation with wrap
        in_valid = 4'hF;
        push(32'hA0, 2'd0); push(32'hA1, 2'd1); push(32'hA2, 2'd2);
        push(32'hA3, 2'd3); push(32'hA0, 2'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_in_ready", {28'd0, in_ready}, 32'(4'b0001 << (k % 4)));
            tick();
        end
        in_valid = 4'h0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rr_drained", {31'd0, out_valid}, 32'h0);
        tick();

        // stall with A1 held, then simultaneous drain and load
        in_valid = 4'b0010;
        push(32'hA1, 2'd1);
        @(negedge clk);
        chk("st_in_ready_pre", {28'd0, in_ready}, 32'h2);
        tick();
        out_ready = 1'b0;
        in_valid  = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("st_out_valid", {31'd0, out_valid}, 32'h1);
            chk("st_out_data", out_data, 32'hA1);
            chk("st_in_ready", {28'd0, in_ready}, 32'h0);
            tick();
        end
        out_ready = 1'b1;
        push(32'hA2, 2'd2);
        @(negedge clk);
        chk("st_release_ready", {28'd0, in_ready}, 32'h4);
        tick();
        in_valid = 4'h0;
        @(negedge clk);
        chk("st_valid_kept", {31'd0, out_valid}, 32'h1);
        chk("st_new_data", out_data, 32'hA2);
        tick();

        // single request on channel 3 brings the pointer back to 0
        in_valid = 4'b1000;
        push(32'hA3, 2'd3);
        @(negedge clk);
        chk("p3_in_ready", {28'd0, in_ready}, 32'h8);
        tick();
        in_valid = 4'h0;
        @(negedge clk);
        tick();

        // force mode on channel 2
        force_en  = 1'b1;
        force_sel = 2'd2;
        in_valid  = 4'hF;
        for (int k = 0; k < 4; k++) begin
            push(32'hA2, 2'd2);
            @(negedge clk);
            chk("frc_in_ready", {28'd0, in_ready}, 32'h4);
            tick();
        end
        in_valid = 4'b1011;
        @(negedge clk);
        chk("frc_no_grant", {28'd0, in_ready}, 32'h0);
        tick();
        @(negedge clk);
        chk("frc_valid_fall", {31'd0, out_valid}, 32'h0);
        tick();

        // sparse round-robin; pointer must still be 0 after force mode
        force_en = 1'b0;
        in_valid = 4'b1001;
        push(32'hA0, 2'd0); push(32'hA3, 2'd3); push(32'hA0, 2'd0); push(32'hA3, 2'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("sp_in_ready", {28'd0, in_ready}, (k % 2 == 1) ? 32'h8 : 32'h1);
            tick();
        end
        in_valid = 4'h0;
        @(negedge clk);
        tick();

        // N=5 instance: out-of-range force_sel, top channel, pointer wrap
        force_en2  = 1'b1;
        force_sel2 = 3'd5;
        in_valid2  = 5'h1F;
        @(negedge clk);
        chk("n5_sel5_ready", {27'd0, in_ready2}, 32'h0);
        tick();
        @(negedge clk);
        chk("n5_sel5_valid", {31'd0, out_valid2}, 32'h0);
        tick();
        force_sel2 = 3'd4;
        @(negedge clk);
        chk("n5_sel4_ready", {27'd0, in_ready2}, 32'h10);
        tick();
        @(negedge clk);
        chk("n5_sel4_valid", {31'd0, out_valid2}, 32'h1);
        chk("n5_sel4_src", {29'd0, out_src2}, 32'h4);
        chk("n5_sel4_data", {24'd0, out_data2}, 32'hB4);
        tick();
        force_en2 = 1'b0;
        in_valid2 = 5'b10000;
        @(negedge clk);
        chk("n5_rr4_ready", {27'd0, in_ready2}, 32'h10);
        tick();
        in_valid2 = 5'b10001;
        @(negedge clk);
        chk("n5_wrap_ready", {27'd0, in_ready2}, 32'h01);
        tick();
        in_valid2 = 5'd0;
        @(negedge clk);
        chk("n5_wrap_src", {29'd0, out_src2}, 32'h0);
        chk("n5_wrap_data", {24'd0, out_data2}, 32'hB0);
        tick();

        // reset mid-stream discards the held word and the pointer
        in_valid  = 4'hF;
        out_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("mr_held_valid", {31'd0, out_valid}, 32'h1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_valid", {31'd0, out_valid}, 32'h0);
        chk("mr_async_ready", {28'd0, in_ready}, 32'h0);
        chk("mr_async_data", out_data, 32'h0);
        in_valid  = 4'b1001;
        out_ready = 1'b1;
        @(posedge clk);
        tick();
        rst_n = 1'b1;
        push(32'hA0, 2'd0);
        @(negedge clk);
        chk("mr_first_ready", {28'd0, in_ready}, 32'h1);
        tick();
        in_valid = 4'h0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("end_out_valid", {31'd0, out_valid}, 32'h0);
        chk("end_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
